// File: rtl/serlink_pkg.sv
// Shared types and constants for the serial-link frame arbiter.
package serlink_pkg;

  localparam int          LEN_W       = 4;
  localparam int          N_REQ       = 2;
  localparam logic [3:0]  HDR_DEFAULT = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CNT,
    S_DATA,
    S_PAR,
    S_GAP
  } state_t;

endpackage

// File: rtl/serlink_rr_arb.sv
// Two-way round-robin picker: registered fairness pointer, combinational one-hot pick.
module serlink_rr_arb
  import serlink_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             complete,
  input  logic             owner,
  output logic [N_REQ-1:0] pick
);

  // ptr == 0 favors requester 0, ptr == 1 favors requester 1.
  logic ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (complete) begin
      ptr <= ~owner;
    end
  end

  always_comb begin
    // NOTE: default assignment before the case keeps this purely combinational (no latch).
    pick = '0;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = ptr ? 2'b10 : 2'b01;
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/serlink_frame_arb.sv
// Round-robin serial-link frame sequencer: header, 4-bit count, LSB-first payload, gap bit.
// Optional feature macro SERLINK_PARITY_EN adds an even-parity bit after the payload.
module serlink_frame_arb
  import serlink_pkg::*;
#(
  parameter logic [3:0] HDR = HDR_DEFAULT,
  parameter int         DW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic [N_REQ-1:0] req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [DW-1:0]    data0,
  input  logic [DW-1:0]    data1,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             SerOut,
  output logic             SerOutValid,
  output logic [LEN_W-1:0] remaining
);

  state_t             state;
  logic [1:0]         idx;
  logic [LEN_W-1:0]   len_q;
  logic [DW-1:0]      shreg;
  logic [N_REQ-1:0]   pick;
  logic               frame_end;
`ifdef SERLINK_PARITY_EN
  logic               par_q;
`endif

  serlink_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .complete (frame_end),
    .owner    (gnt[1]),
    .pick     (pick)
  );

  // The tick that retires the last frame bit: it launches the gap bit and pulses done.
`ifdef SERLINK_PARITY_EN
  assign frame_end = bit_en && (state == S_PAR);
`else
  assign frame_end = bit_en && (state == S_DATA) && (remaining == '0);
`endif

  // State names what is currently on the line; idx is the bit index within HDR/CNT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      len_q       <= '0;
      // NOTE: the payload register is reset too, so an abandoned frame leaves nothing behind.
      shreg       <= '0;
      gnt         <= '0;
      done        <= '0;
      SerOut      <= 1'b0;
      SerOutValid <= 1'b0;
      remaining   <= '0;
`ifdef SERLINK_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment overrides this default.
      done <= '0;
      if (frame_end) begin
        SerOut      <= 1'b0;
        SerOutValid <= 1'b0;
        gnt         <= '0;
        done        <= gnt;
        state       <= S_GAP;
      end else if (bit_en) begin
        case (state)
          S_IDLE, S_GAP: begin
            if (|pick) begin
              gnt    <= pick;
              len_q  <= pick[0] ? len0 : len1;
              shreg  <= pick[0] ? data0 : data1;
              SerOut <= HDR[3];
              idx    <= 2'd3;
              state  <= S_HDR;
            end else begin
              SerOut <= 1'b0;
              state  <= S_IDLE;
            end
          end
          S_HDR: begin
            if (idx == 2'd0) begin
              SerOut <= len_q[3];
              idx    <= 2'd3;
              state  <= S_CNT;
            end else begin
              SerOut <= HDR[idx - 2'd1];
              idx    <= idx - 2'd1;
            end
          end
          S_CNT: begin
            if (idx == 2'd0) begin
              SerOut      <= shreg[0];
              shreg       <= shreg >> 1;
              SerOutValid <= 1'b1;
              remaining   <= len_q;
              state       <= S_DATA;
`ifdef SERLINK_PARITY_EN
              par_q       <= shreg[0];
`endif
            end else begin
              SerOut <= len_q[idx - 2'd1];
              idx    <= idx - 2'd1;
            end
          end
          S_DATA: begin
`ifdef SERLINK_PARITY_EN
            if (remaining == '0) begin
              SerOut      <= par_q;
              SerOutValid <= 1'b0;
              state       <= S_PAR;
            end else
`endif
            begin
              SerOut    <= shreg[0];
              shreg     <= shreg >> 1;
              remaining <= remaining - LEN_W'(1);
`ifdef SERLINK_PARITY_EN
              par_q     <= par_q ^ shreg[0];
`endif
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/serlink_frame_arb.md
# serlink_frame_arb

Two-requester serial-link arbiter and frame sequencer. Accepts payload requests from two sources, grants the single serial line round-robin, and serializes each grant as a frame: header 1011, 4-bit count, then count+1 payload bits. Sits upstream of the Moore serial detector and drives its serial input; `remaining` feeds the seven-segment display path.

## Interface
- `HDR`, default 4'b1011: frame header, sent MSB first.
- `DW`, default 16: payload register width; must be ≥ 16.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `bit_en`  in  1  one-cycle strobe; advances the line by one bit (debounced push-button edge).
- `req`  in  2  level request per requester; held until its `done` pulse.
- `len0`, `len1`  in  4 each  payload length minus one.
- `data0`, `data1`  in  DW each  payload, sent LSB first.
- `gnt`  out  2  one-hot owner of the current frame; 00 when idle.
- `done`  out  2  one-clk pulse to the requester whose frame completed.
- `SerOut`  out  1  serial line, registered.
- `SerOutValid`  out  1  high while a payload bit is on `SerOut`.
- `remaining`  out  4  payload bits still to send after the current one.

## Operation
- States: IDLE, HDR, CNT, DATA, (PAR), GAP.
- State, `SerOut`, `SerOutValid`, `remaining` change only on cycles with `bit_en`=1. `done` is the only exception; it self-clears the following clk.
- IDLE/GAP on `bit_en`: the round-robin pick among asserted `req` bits sets `gnt` and latches `len`/`data` of the winner. SerOut<=HDR[3], go to HDR. With no request, go to IDLE with SerOut<=0.
- HDR: sends HDR[2:0] on successive ticks, then CNT.
- CNT: sends len[3:0] MSB first. On the tick after len[0], go to DATA.
- DATA: sends data[0] … data[len]. SerOutValid=1 and `remaining` counts len down to 0.
- After data[len], go to GAP: SerOut<=0, SerOutValid<=0, `gnt` cleared, `done[owner]` pulses.
- GAP lasts exactly one bit period, which guarantees ≥1 low idle bit between frames.
- Frame length on the line: 8 + (len+1) bits, plus 1 gap bit.
- Round robin:
  - A pointer favors requester 0 after reset.
  - After a frame from requester k completes, the pointer favors 1−k.
  - With a single requester asserted, it wins regardless of the pointer.
- Requester inputs are sampled only at grant. Changes to `req`, `len`, or `data` mid-frame are ignored, and the frame completes.
- Async reset at any time puts the block in IDLE with:
  - `gnt`=00, `done`=00, `SerOut`=0, `SerOutValid`=0, `remaining`=0.
  - Pointer favoring requester 0. Any partial frame is abandoned.

## Timing
- Grant latency: the `bit_en` cycle that sees a request in IDLE/GAP. `SerOut`=1 and `gnt` are valid the next clk.
- Each line bit is stable for the full interval between consecutive `bit_en` strobes.
- `done` rises on the clk after the `bit_en` that ends DATA (or PAR), and is high for exactly one clk.
- `bit_en` held low freezes every output except `done`.
- `bit_en` is assumed synchronous to `clk` and at most one cycle wide per tick.

## Configuration
- `SERLINK_PARITY_EN` defined:
  - A PAR state follows DATA. It sends the even-parity bit (XOR of data[0..len]) with SerOutValid=0.
  - GAP follows PAR. Frame is 10+len bits plus gap.
- Undefined: no PAR state; DATA goes directly to GAP.

## Structure
- Package `serlink_pkg` holds:
  - State enum.
  - HDR default constant.
  - Length width (4).
  - Requester count (2).
- Sub-module `serlink_rr_arb`: 2-way round-robin picker with pointer update on completion. Purely sequential pointer plus combinational pick.
- The top holds the frame FSM, bit index counter, and payload shift register.

## Test plan
- Reset mid-DATA with rst low for 3 clk → `gnt`=00, `SerOut`=0, `SerOutValid`=0, `remaining`=0. After release, next frame starts with header.
- req0, len0=3, data0=16'h000D → SerOut over 12 ticks = 1,0,1,1, 0,0,1,1, 1,0,1,1, then 0. SerOutValid high for the last 4 bits, `remaining` 3,2,1,0. Single `done[0]` pulse.
- req both from reset, held after each `done` → grant order 0,1,0,1. Gap bit 0 between every frame.
- len1=15, data1=16'hFFFF → 16 consecutive payload ones, `remaining` 15→0, total 24 bits plus gap.
- Drop req0 and change data0 mid-CNT → frame completes with the latched data. Hold `bit_en` low 20 clk → outputs frozen.
- With `SERLINK_PARITY_EN`, len0=2, data0=16'h0007 → payload 1,1,1 then parity 1 with SerOutValid=0, then gap 0.
